// File: rtl/egg_timer_pkg.sv
// Shared constants and helpers for the egg timer: BCD digit width, per-digit limits
// and the clamp applied to out-of-range programmed digits.
package egg_timer_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] SEC_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] TSEC_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] MIN_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] TMIN_MAX = 4'd9;

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] v,
                                                     input logic [DIGIT_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

endpackage

// File: rtl/egg_timer_if.sv
// Settings/display bus of the egg timer core: keypad-side controls and programmed
// digits in, current digits, tick and done flag out.
interface egg_timer_if;
  import egg_timer_pkg::*;

  logic               main_enable;
  logic               load;
  logic               direction;
  logic [DIGIT_W-1:0] seconds_prog;
  logic [DIGIT_W-1:0] tens_seconds_prog;
  logic [DIGIT_W-1:0] minutes_prog;
  logic [DIGIT_W-1:0] tens_minutes_prog;
  logic [DIGIT_W-1:0] seconds;
  logic [DIGIT_W-1:0] tens_seconds;
  logic [DIGIT_W-1:0] minutes;
  logic [DIGIT_W-1:0] tens_minutes;
  logic               pulse;
  logic               done;

  modport master (
    output main_enable, load, direction,
           seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog,
    input  seconds, tens_seconds, minutes, tens_minutes, pulse, done
  );

  modport slave (
    input  main_enable, load, direction,
           seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog,
    output seconds, tens_seconds, minutes, tens_minutes, pulse, done
  );

endinterface

// File: rtl/egg_timer_tick_divider.sv
// Free-running divider: one registered single-cycle pulse every MAX_COUNT+1 clocks.
// clear restarts the period so the next pulse lands one full period later.
module tick_divider #(
  parameter int MAX_COUNT = 4_999_999,
  parameter int CTR_WIDTH = 23
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic pulse
);

  logic [CTR_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pulse_q, pulse_d;

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    pulse_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == CTR_WIDTH'(MAX_COUNT)) begin
      cnt_d   = '0;
      pulse_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/egg_timer_core.sv
// MM:SS BCD timekeeper: four digit registers that load, count down or count up once per
// divider tick, saturating at 00:00 and 99:59.
module egg_timer_core
  import egg_timer_pkg::*;
#(
  parameter int MAX_COUNT = 4_999_999,
  parameter int CTR_WIDTH = 23
) (
  input  logic       clk,
  input  logic       reset,
  egg_timer_if.slave bus
);

  logic               pulse;
  logic               step;
  logic               all_zero, all_max;
  logic [DIGIT_W-1:0] sec_q, tsec_q, min_q, tmin_q;
  logic [DIGIT_W-1:0] sec_d, tsec_d, min_d, tmin_d;

  tick_divider #(.MAX_COUNT(MAX_COUNT), .CTR_WIDTH(CTR_WIDTH)) u_div (
    .clk   (clk),
    .reset (reset),
    .clear (bus.load),
    .pulse (pulse)
  );

  assign step     = pulse & bus.main_enable & ~bus.load;
  assign all_zero = (sec_q == '0) && (tsec_q == '0) && (min_q == '0) && (tmin_q == '0);
  assign all_max  = (sec_q == SEC_MAX) && (tsec_q == TSEC_MAX) &&
                    (min_q == MIN_MAX) && (tmin_q == TMIN_MAX);

  // Borrow/carry ripples only as far as the digit below wrapped; saturation blocks the step.
  always_comb begin
    sec_d  = sec_q;
    tsec_d = tsec_q;
    min_d  = min_q;
    tmin_d = tmin_q;
    if (bus.load) begin
      sec_d  = clamp_digit(bus.seconds_prog,      SEC_MAX);
      tsec_d = clamp_digit(bus.tens_seconds_prog, TSEC_MAX);
      min_d  = clamp_digit(bus.minutes_prog,      MIN_MAX);
      tmin_d = clamp_digit(bus.tens_minutes_prog, TMIN_MAX);
    end else if (step && !bus.direction && !all_zero) begin
      sec_d = (sec_q == '0) ? SEC_MAX : sec_q - 4'd1;
      if (sec_q == '0) begin
        tsec_d = (tsec_q == '0) ? TSEC_MAX : tsec_q - 4'd1;
        if (tsec_q == '0) begin
          min_d = (min_q == '0) ? MIN_MAX : min_q - 4'd1;
          if (min_q == '0) tmin_d = tmin_q - 4'd1;
        end
      end
    end else if (step && bus.direction && !all_max) begin
      sec_d = (sec_q == SEC_MAX) ? '0 : sec_q + 4'd1;
      if (sec_q == SEC_MAX) begin
        tsec_d = (tsec_q == TSEC_MAX) ? '0 : tsec_q + 4'd1;
        if (tsec_q == TSEC_MAX) begin
          min_d = (min_q == MIN_MAX) ? '0 : min_q + 4'd1;
          if (min_q == MIN_MAX) tmin_d = tmin_q + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sec_q  <= '0;
      tsec_q <= '0;
      min_q  <= '0;
      tmin_q <= '0;
    end else begin
      sec_q  <= sec_d;
      tsec_q <= tsec_d;
      min_q  <= min_d;
      tmin_q <= tmin_d;
    end
  end

  assign bus.seconds      = sec_q;
  assign bus.tens_seconds = tsec_q;
  assign bus.minutes      = min_q;
  assign bus.tens_minutes = tmin_q;
  assign bus.pulse        = pulse;
  assign bus.done         = ~bus.direction & all_zero;

endmodule

// File: tb/tb_egg_timer_core.sv
// Bench for egg_timer_core with MAX_COUNT=9: directed scenarios plus a randomized run,
// all compared against a reference that keeps the time as a plain count of seconds.
module tb_egg_timer_core;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   mon_en  = 1'b0;

  egg_timer_if bus ();

  egg_timer_core #(.MAX_COUNT(9), .CTR_WIDTH(4)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: phase counter, tick flag and elapsed time in whole seconds (0..5999).
  int m_cnt   = 0;
  bit m_pulse = 1'b0;
  int m_total = 0;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int prog_total();
    return min_i(int'(bus.tens_minutes_prog), 9) * 600 + min_i(int'(bus.minutes_prog), 9) * 60 +
           min_i(int'(bus.tens_seconds_prog), 5) * 10 + min_i(int'(bus.seconds_prog), 9);
  endfunction

  function automatic logic [15:0] to_bcd(input int t);
    logic [15:0] r;
    r[15:12] = 4'(t / 600);
    r[11:8]  = 4'((t / 60) % 10);
    r[7:4]   = 4'((t % 60) / 10);
    r[3:0]   = 4'(t % 10);
    return r;
  endfunction

  function automatic logic [15:0] dut_digits();
    return {bus.tens_minutes, bus.minutes, bus.tens_seconds, bus.seconds};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= 0;
      m_pulse <= 1'b0;
      m_total <= 0;
    end else if (bus.load) begin
      m_cnt   <= 0;
      m_pulse <= 1'b0;
      m_total <= prog_total();
    end else begin
      if (m_pulse && bus.main_enable) begin
        if (bus.direction) m_total <= (m_total < 5999) ? m_total + 1 : m_total;
        else               m_total <= (m_total > 0) ? m_total - 1 : 0;
      end
      m_cnt   <= (m_cnt == 9) ? 0 : m_cnt + 1;
      m_pulse <= (m_cnt == 9);
    end
  end

  always @(posedge clk) begin
    #3;
    if (mon_en) begin
      chk("mon_digits", 32'(dut_digits()), 32'(to_bcd(m_total)));
      chk("mon_pulse", 32'(bus.pulse), 32'(m_pulse));
      chk("mon_done", 32'(bus.done), 32'(!bus.direction && m_total == 0));
    end
  end

  task automatic load_bcd(input logic [3:0] tm, input logic [3:0] m,
                          input logic [3:0] ts, input logic [3:0] s);
    @(negedge clk);
    bus.tens_minutes_prog = tm;
    bus.minutes_prog      = m;
    bus.tens_seconds_prog = ts;
    bus.seconds_prog      = s;
    bus.load              = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Each iteration waits for a tick, then one more edge so the step has been applied.
  task automatic wait_steps(input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      @(negedge clk);
      while (bus.pulse !== 1'b1 && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 40) begin
        chk("pulse_timeout", 32'(guard), 32'd0);
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int npulse;
    int first;
    bus.main_enable       = 1'b0;
    bus.load              = 1'b0;
    bus.direction         = 1'b0;
    bus.seconds_prog      = '0;
    bus.tens_seconds_prog = '0;
    bus.minutes_prog      = '0;
    bus.tens_minutes_prog = '0;
    repeat (3) @(negedge clk);
    chk("rst_digits", 32'(dut_digits()), 32'h0);
    chk("rst_pulse", 32'(bus.pulse), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h1);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    npulse = 0;
    first  = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (bus.pulse === 1'b1) begin
        npulse++;
        if (first == 0) first = c;
      end
    end
    chk("idle_pulses", 32'(npulse), 32'd3);
    chk("idle_first_pulse", 32'(first), 32'd10);
    chk("idle_digits", 32'(dut_digits()), 32'h0);

    bus.main_enable = 1'b1;
    bus.direction   = 1'b0;
    load_bcd(4'd1, 4'd2, 4'd3, 4'd4);
    chk("load_1234", 32'(dut_digits()), 32'h1234);
    wait_steps(5);
    chk("down_1229", 32'(dut_digits()), 32'h1229);
    wait_steps(30);
    chk("down_1159", 32'(dut_digits()), 32'h1159);

    load_bcd(4'd0, 4'd0, 4'd0, 4'd2);
    wait_steps(1);
    chk("down_0001", 32'(dut_digits()), 32'h0001);
    chk("done_0001", 32'(bus.done), 32'h0);
    wait_steps(1);
    chk("down_0000", 32'(dut_digits()), 32'h0000);
    wait_steps(5);
    chk("hold_0000", 32'(dut_digits()), 32'h0000);
    chk("hold_done", 32'(bus.done), 32'h1);

    bus.direction = 1'b1;
    load_bcd(4'd9, 4'd9, 4'd5, 4'd8);
    wait_steps(1);
    chk("up_9959", 32'(dut_digits()), 32'h9959);
    wait_steps(3);
    chk("hold_9959", 32'(dut_digits()), 32'h9959);
    load_bcd(4'd0, 4'd9, 4'd5, 4'd9);
    wait_steps(1);
    chk("up_1000", 32'(dut_digits()), 32'h1000);

    bus.direction = 1'b0;
    load_bcd(4'd0, 4'd5, 4'd0, 4'd0);
    wait_steps(2);
    chk("down_0458", 32'(dut_digits()), 32'h0458);
    bus.main_enable = 1'b0;
    wait_steps(3);
    chk("frozen_0458", 32'(dut_digits()), 32'h0458);
    bus.main_enable = 1'b1;
    wait_steps(1);
    chk("resume_0457", 32'(dut_digits()), 32'h0457);

    load_bcd(4'd0, 4'd15, 4'd7, 4'd15);
    chk("clamp_0959", 32'(dut_digits()), 32'h0959);
    wait_steps(2);
    chk("down_0957", 32'(dut_digits()), 32'h0957);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_digits", 32'(dut_digits()), 32'h0);
    chk("async_rst_pulse", 32'(bus.pulse), 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(39) == 0) begin
        bus.tens_minutes_prog = 4'($urandom_range(15));
        bus.minutes_prog      = 4'($urandom_range(15));
        bus.tens_seconds_prog = 4'($urandom_range(15));
        bus.seconds_prog      = 4'($urandom_range(15));
        bus.load              = 1'b1;
      end else begin
        bus.load = ($urandom_range(199) == 0);
      end
      if ($urandom_range(29) == 0) bus.main_enable = ~bus.main_enable;
      if ($urandom_range(49) == 0) bus.direction   = ~bus.direction;
      if ($urandom_range(699) == 0) begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
    end
    bus.load = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
